axilite_m: RTL and testbench
============================

// Module: axilite_m
// PURPOSE
//  AXI4-Lite master (initiator): turns single-beat commands from a simple local
//  port into AXI4-Lite write (AW/W/B) or read (AR/R) transactions.
//  Pairs with the axilite_s slave: system-level driver and self-checking bench partner.
//  One outstanding transaction; result returned as a one-cycle response pulse.
// PARAMETERS
//  ADDR_W          32   address width (cmd_addr, m_axi_awaddr, m_axi_araddr)
//  DATA_W          32   data width (cmd_wdata, m_axi_wdata, m_axi_rdata, rsp_rdata)
//  TIMEOUT_CYCLES  256  watchdog limit; used only with AXILITE_M_TIMEOUT_EN
// PORTS
//  m_axi_aclk     in   1       clock; all logic on rising edge
//  m_axi_aresetn  in   1       reset, synchronous, active-low
//  cmd_valid      in   1       command request
//  cmd_ready      out  1       command accepted when cmd_valid && cmd_ready
//  cmd_write      in   1       1 = write, 0 = read
//  cmd_addr       in   ADDR_W  transaction address
//  cmd_wdata      in   DATA_W  write data (ignored for reads)
//  rsp_valid      out  1       one-cycle pulse: transaction complete
//  rsp_write      out  1       completed transaction was a write
//  rsp_resp       out  2       BRESP/RRESP, or 2'b11 on timeout
//  rsp_rdata      out  DATA_W  read data (0 for writes)
//  m_axi_awvalid/awready out/in 1; m_axi_awaddr out ADDR_W   write address channel
//  m_axi_wvalid/wready   out/in 1; m_axi_wdata  out DATA_W   write data channel
//  m_axi_bvalid/bready   in/out 1; m_axi_bresp  in  2        write response channel
//  m_axi_arvalid/arready out/in 1; m_axi_araddr out ADDR_W   read address channel
//  m_axi_rvalid/rready   in/out 1; m_axi_rdata  in DATA_W; m_axi_rresp in 2
// BEHAVIOUR
//  Reset (m_axi_aresetn==0 at posedge)
//  - state=IDLE; all *valid, *ready, rsp_* and address/data outputs = 0.
//  - Reset mid-transaction abandons it; no rsp_valid is produced.
//  FSM: IDLE -> WR -> WR_B -> IDLE | IDLE -> RD_A -> RD_R -> IDLE
//  IDLE
//  - cmd_ready=1 only here.
//  - On accept, cmd_addr/cmd_wdata/cmd_write are registered.
//  - AWVALID+WVALID (write) or ARVALID (read) go high the next cycle.
//  WR
//  - AWVALID and WVALID asserted together; each drops independently on its own
//    handshake (valid && ready at posedge).
//  - Either order, or both in the same cycle, is legal.
//  - Leave for WR_B when both handshakes are done.
//  - Payloads stay stable while the corresponding valid is high.
//  - Valid is never withdrawn before its handshake.
//  WR_B
//  - BREADY=1; on BVALID: capture BRESP, go to IDLE.
//  - rsp_valid=1, rsp_write=1, rsp_rdata=0 in that next cycle.
//  RD_A
//  - ARVALID=1 until ARREADY handshake, then RD_R.
//  RD_R
//  - RREADY=1; on RVALID: capture RDATA/RRESP, go to IDLE.
//  - rsp_valid pulse next cycle with rsp_write=0.
//  Latency
//  - Accept at edge N: AW/W or AR valid visible after edge N.
//  - rsp_valid asserted the cycle after the B/R handshake.
//  - New command acceptable in that same rsp_valid cycle, so 0 bubble between results.
//  Boundaries
//  - cmd_valid outside IDLE is ignored (cmd_ready=0).
//  - BVALID/RVALID arriving early is held by the slave and taken once in WR_B/RD_R.
//  - rsp_* hold their values until the next response; only rsp_valid pulses.
// CONFIGURATION
//  AXILITE_M_TIMEOUT_EN defined
//  - Counter clears on entry to each non-IDLE state and increments every cycle
//    in WR/WR_B/RD_A/RD_R.
//  - On reaching TIMEOUT_CYCLES-1: all valids/readies drop, FSM -> IDLE,
//    rsp_valid pulse with rsp_resp=2'b11, rsp_rdata=0.
//  Undefined
//  - No counter; the master waits indefinitely for handshakes.
// TESTING
//  1 Write addr 0x87 data 0xC0DECAFE to axilite_s; awready/wready same cycle
//    -> one AW and one W handshake, rsp_valid=1, rsp_write=1, rsp_resp=2'b00.
//  2 Read 0x87 after test 1 -> ARADDR=0x87; rsp_rdata=0xC0DECAFE,
//    rsp_resp=2'b00, rsp_write=0.
//  3 Stub slave: awready 3 cycles before wready, then wready 3 cycles before
//    awready -> AWVALID/WVALID each drop alone; exactly one B handshake; rsp_valid pulse.
//  4 Back-to-back: write 0x10=0x1, read 0x10, driven on rsp_valid cycles
//    -> accepted without idle cycles; read returns 0x1.
//  5 Reset asserted during WR_B (bvalid withheld) -> all outputs 0 next cycle;
//    no rsp_valid; next command completes normally.
//  6 With AXILITE_M_TIMEOUT_EN, TIMEOUT_CYCLES=16, arready tied 0
//    -> ARVALID drops after 16 cycles; rsp_resp=2'b11.
//    Without the macro, ARVALID stays high.

Source files
------------

// File: rtl/axilite_m.sv
// rtl/axilite_m.sv - AXI4-Lite master turning single-beat local commands into AW/W/B or AR/R transactions
// Optional watchdog enabled by defining AXILITE_M_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module axilite_m #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              m_axi_aclk,
  input  logic              m_axi_aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [1:0]        rsp_resp,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  output logic [DATA_W-1:0] m_axi_wdata,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  input  logic [1:0]        m_axi_bresp,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WR   = 3'd1;
  localparam logic [2:0] ST_WR_B = 3'd2;
  localparam logic [2:0] ST_RD_A = 3'd3;
  localparam logic [2:0] ST_RD_R = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [1:0]        rsp_resp_q, rsp_resp_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              timeout;

`ifdef AXILITE_M_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TMO_W-1:0] tmo_q, tmo_d;

  assign timeout = (state_q != ST_IDLE) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Counter restarts whenever the FSM moves, so each wait phase gets the full budget.
  always_comb begin
    tmo_d = tmo_q + 1'b1;
    if (state_d == ST_IDLE || state_d != state_q) begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    araddr_d    = araddr_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = ST_RD_A;
          end
        end
      end
      ST_WR: begin
        if (awvalid_q && m_axi_awready) begin
          awvalid_d = 1'b0;
        end
        if (wvalid_q && m_axi_wready) begin
          wvalid_d = 1'b0;
        end
        if (!awvalid_d && !wvalid_d) begin
          state_d = ST_WR_B;
        end
      end
      ST_WR_B: begin
        if (bready_q && m_axi_bvalid) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_resp_d  = m_axi_bresp;
          rsp_rdata_d = '0;
        end
      end
      ST_RD_A: begin
        if (arvalid_q && m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = ST_RD_R;
        end
      end
      ST_RD_R: begin
        if (rready_q && m_axi_rvalid) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_resp_d  = m_axi_rresp;
          rsp_rdata_d = m_axi_rdata;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Watchdog abort overrides whatever the channel logic decided this cycle.
    if (timeout) begin
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      arvalid_d   = 1'b0;
      state_d     = ST_IDLE;
      rsp_valid_d = 1'b1;
      rsp_write_d = (state_q == ST_WR) || (state_q == ST_WR_B);
      rsp_resp_d  = 2'b11;
      rsp_rdata_d = '0;
    end

    cmd_ready_d = (state_d == ST_IDLE);
    bready_d    = (state_d == ST_WR_B);
    rready_d    = (state_d == ST_RD_R);
  end

  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      araddr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_resp_q  <= 2'b00;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      araddr_q    <= araddr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_rready  = rready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_rdata     = rsp_rdata_q;

endmodule

// File: tb/tb_axilite_m.sv
// tb/tb_axilite_m.sv - scoreboard bench for axilite_m against a behavioural AXI4-Lite slave
// Timeout scenario expectations follow AXILITE_M_TIMEOUT_EN.
module tb_axilite_m;

  typedef logic [34:0] rsp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid, rsp_write;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_rdata;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [1:0]  m_axi_bresp, m_axi_rresp;

  int compared = 0;
  int mismatched = 0;

  rsp_t exp_q[$];
  rsp_t got_q[$];
  logic [31:0] model_mem [0:255];

  int aw_wait = 0, w_wait = 0, ar_wait = 0;
  logic hold_b = 1'b0, ar_block = 1'b0;

  // Slave-side state
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  int aw_hs = 0, w_hs = 0, b_hs = 0;
  int aw_only = 0, w_only = 0, rsp_count = 0;
  logic aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0, rvalid_r = 1'b0;
  logic [31:0] lat_awaddr = '0, lat_wdata = '0, lat_araddr = '0, rdata_r = '0;
  logic [31:0] slv_mem [0:255];

  axilite_m #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp)
  );

  always #5 clk = ~clk;

  assign m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_wait);
  assign m_axi_wready  = m_axi_wvalid && (w_cnt >= w_wait);
  assign m_axi_arready = m_axi_arvalid && !ar_block && (ar_cnt >= ar_wait);
  assign m_axi_bvalid  = b_pend && !hold_b;
  assign m_axi_bresp   = 2'b00;
  assign m_axi_rvalid  = rvalid_r;
  assign m_axi_rdata   = rdata_r;
  assign m_axi_rresp   = 2'b00;

  always @(posedge clk) begin
    if (!resetn) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; rvalid_r <= 1'b0;
    end else begin
      if (m_axi_awvalid && m_axi_awready) begin
        aw_got <= 1'b1; lat_awaddr <= m_axi_awaddr; aw_hs <= aw_hs + 1; aw_cnt <= 0;
      end else if (m_axi_awvalid) begin
        aw_cnt <= aw_cnt + 1;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        w_got <= 1'b1; lat_wdata <= m_axi_wdata; w_hs <= w_hs + 1; w_cnt <= 0;
      end else if (m_axi_wvalid) begin
        w_cnt <= w_cnt + 1;
      end
      if (aw_got && w_got) begin
        slv_mem[lat_awaddr[7:0]] <= lat_wdata;
        aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        b_pend <= 1'b0; b_hs <= b_hs + 1;
      end
      if (m_axi_arvalid && m_axi_arready) begin
        rvalid_r <= 1'b1; rdata_r <= slv_mem[m_axi_araddr[7:0]];
        lat_araddr <= m_axi_araddr; ar_cnt <= 0;
      end else if (m_axi_arvalid) begin
        ar_cnt <= ar_cnt + 1;
      end
      if (rvalid_r && m_axi_rready) rvalid_r <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rsp_valid) begin
      got_q.push_back({rsp_write, rsp_resp, rsp_rdata});
      rsp_count++;
    end
    if (m_axi_awvalid && !m_axi_wvalid) aw_only++;
    if (!m_axi_awvalid && m_axi_wvalid) w_only++;
  end

  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    bit seen = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    for (int i = 0; i < 60; i++) begin
      if (cmd_ready) begin seen = 1; break; end
      @(negedge clk);
    end
    if (!seen) begin
      compared++; mismatched++;
      $display("FAIL cmd_accept: cmd_ready never seen for addr %h, required 1", a);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic pop_pair(output bit ok, output rsp_t got, output rsp_t exp);
    ok = 0; got = '0; exp = '0;
    for (int i = 0; i < 200 && got_q.size() == 0; i++) @(negedge clk);
    if (got_q.size() != 0 && exp_q.size() != 0) begin
      ok = 1; got = got_q.pop_front(); exp = exp_q.pop_front();
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid} !== 7'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %b required 0", {cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid});
    end
    resetn = 1'b1;
    @(negedge clk);
    compared++;
    if (cmd_ready !== 1'b1) begin
      mismatched++; $display("FAIL idle_ready: cmd_ready got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_write_read;
    bit ok; rsp_t g, e;
    int aw0 = aw_hs, w0 = w_hs, ao0 = aw_only, wo0 = w_only;
    aw_wait = 0; w_wait = 0;
    send_cmd(1'b1, 32'h87, 32'hC0DECAFE);
    exp_q.push_back({1'b1, 2'b00, 32'h0}); model_mem[8'h87] = 32'hC0DECAFE;
    pop_pair(ok, g, e);
    compared++;
    if (!ok || g !== e) begin mismatched++; $display("FAIL write_rsp: got %h (ok=%0d) required %h", g, ok, e); end
    compared++;
    if ((aw_hs - aw0) != 1 || (w_hs - w0) != 1) begin
      mismatched++; $display("FAIL write_hs: aw %0d w %0d required 1 1", aw_hs - aw0, w_hs - w0);
    end
    compared++;
    if (lat_awaddr !== 32'h87 || lat_wdata !== 32'hC0DECAFE) begin
      mismatched++; $display("FAIL write_payload: addr %h data %h required 87 c0decafe", lat_awaddr, lat_wdata);
    end
    compared++;
    if (aw_only != ao0 || w_only != wo0) begin
      mismatched++; $display("FAIL write_same_cycle: lone cycles aw %0d w %0d required 0 0", aw_only - ao0, w_only - wo0);
    end
    send_cmd(1'b0, 32'h87, 32'h0);
    exp_q.push_back({1'b0, 2'b00, model_mem[8'h87]});
    pop_pair(ok, g, e);
    compared++;
    if (!ok || g !== e) begin mismatched++; $display("FAIL read_rsp: got %h (ok=%0d) required %h", g, ok, e); end
    compared++;
    if (lat_araddr !== 32'h87) begin mismatched++; $display("FAIL read_addr: got %h required 87", lat_araddr); end
    repeat (3) @(negedge clk);
    compared++;
    if ({rsp_valid, rsp_write, rsp_resp, rsp_rdata} !== {1'b0, e}) begin
      mismatched++; $display("FAIL rsp_hold: got %h required %h", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, {1'b0, e});
    end
  endtask

  task automatic test_ordering;
    bit ok; rsp_t g, e;
    for (int k = 0; k < 2; k++) begin
      int aw0 = aw_hs, w0 = w_hs, b0 = b_hs, ao0 = aw_only, wo0 = w_only, r0 = rsp_count;
      aw_wait = (k == 0) ? 0 : 3;
      w_wait  = (k == 0) ? 3 : 0;
      send_cmd(1'b1, 32'h30 + 32'(k * 4), 32'hA5000000 + 32'(k));
      exp_q.push_back({1'b1, 2'b00, 32'h0});
      model_mem[8'h30 + 8'(k * 4)] = 32'hA5000000 + 32'(k);
      pop_pair(ok, g, e);
      repeat (3) @(negedge clk);
      compared++;
      if (!ok || g !== e) begin mismatched++; $display("FAIL order%0d_rsp: got %h (ok=%0d) required %h", k, g, ok, e); end
      compared++;
      if ((k == 0 && ((w_only - wo0) != 3 || aw_only != ao0)) || (k == 1 && ((aw_only - ao0) != 3 || w_only != wo0))) begin
        mismatched++; $display("FAIL order%0d_lone: aw_only %0d w_only %0d", k, aw_only - ao0, w_only - wo0);
      end
      compared++;
      if ((aw_hs - aw0) != 1 || (w_hs - w0) != 1 || (b_hs - b0) != 1 || (rsp_count - r0) != 1) begin
        mismatched++; $display("FAIL order%0d_hs: aw %0d w %0d b %0d rsp %0d required 1 1 1 1", k, aw_hs - aw0, w_hs - w0, b_hs - b0, rsp_count - r0);
      end
    end
    aw_wait = 0; w_wait = 0;
  endtask

  task automatic test_back_to_back;
    bit ok, seen; rsp_t g, e;
    seen = 0;
    send_cmd(1'b1, 32'h10, 32'h1);
    exp_q.push_back({1'b1, 2'b00, 32'h0}); model_mem[8'h10] = 32'h1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1; break; end
    end
    compared++;
    if (!seen || cmd_ready !== 1'b1) begin
      mismatched++; $display("FAIL b2b_ready: rsp seen %0d cmd_ready %b required 1 1", seen, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    exp_q.push_back({1'b0, 2'b00, model_mem[8'h10]});
    compared++;
    if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 32'h10) begin
      mismatched++; $display("FAIL b2b_ar: arvalid %b araddr %h required 1 10", m_axi_arvalid, m_axi_araddr);
    end
    for (int j = 0; j < 2; j++) begin
      pop_pair(ok, g, e);
      compared++;
      if (!ok || g !== e) begin mismatched++; $display("FAIL b2b_rsp%0d: got %h (ok=%0d) required %h", j, g, ok, e); end
    end
  endtask

  task automatic test_reset_mid;
    bit ok, seen; rsp_t g, e;
    int r0;
    seen = 0;
    hold_b = 1'b1;
    send_cmd(1'b1, 32'h20, 32'hDEAD0001);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m_axi_bready) begin seen = 1; break; end
    end
    r0 = rsp_count;
    resetn = 1'b0;
    @(posedge clk); #1;
    compared++;
    if (!seen || {cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
                  rsp_valid, rsp_write, rsp_resp, rsp_rdata, m_axi_awaddr, m_axi_wdata, m_axi_araddr} !== '0) begin
      mismatched++;
      $display("FAIL midreset_outputs: bready seen %0d awaddr %h wdata %h rsp_rdata %h bready %b required all 0",
               seen, m_axi_awaddr, m_axi_wdata, rsp_rdata, m_axi_bready);
    end
    @(negedge clk);
    resetn = 1'b1; hold_b = 1'b0;
    repeat (6) @(negedge clk);
    compared++;
    if (rsp_count != r0 || got_q.size() != 0) begin
      mismatched++; $display("FAIL midreset_norsp: %0d responses required 0", rsp_count - r0);
    end
    send_cmd(1'b1, 32'h24, 32'h5A5A5A5A);
    exp_q.push_back({1'b1, 2'b00, 32'h0}); model_mem[8'h24] = 32'h5A5A5A5A;
    pop_pair(ok, g, e);
    compared++;
    if (!ok || g !== e) begin mismatched++; $display("FAIL midreset_wr: got %h (ok=%0d) required %h", g, ok, e); end
    send_cmd(1'b0, 32'h24, 32'h0);
    exp_q.push_back({1'b0, 2'b00, model_mem[8'h24]});
    pop_pair(ok, g, e);
    compared++;
    if (!ok || g !== e) begin mismatched++; $display("FAIL midreset_rd: got %h (ok=%0d) required %h", g, ok, e); end
  endtask

  task automatic test_timeout;
    bit ok; rsp_t g, e;
    int ar_cycles = 0;
    bit busy_ready = 0;
    ar_block = 1'b1;
    send_cmd(1'b0, 32'h44, 32'h0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_axi_arvalid) begin
        ar_cycles++;
        if (cmd_ready) busy_ready = 1;
      end
    end
    compared++;
    if (busy_ready) begin mismatched++; $display("FAIL busy_ready: cmd_ready 1 while busy, required 0"); end
`ifdef AXILITE_M_TIMEOUT_EN
    compared++;
    if (ar_cycles != 16) begin mismatched++; $display("FAIL tmo_ar_cycles: got %0d required 16", ar_cycles); end
    exp_q.push_back({1'b0, 2'b11, 32'h0});
    pop_pair(ok, g, e);
    compared++;
    if (!ok || g !== e) begin mismatched++; $display("FAIL tmo_rsp: got %h (ok=%0d) required %h", g, ok, e); end
    ar_block = 1'b0;
`else
    compared++;
    if (ar_cycles != 40 || got_q.size() != 0) begin
      mismatched++; $display("FAIL no_tmo_ar: arvalid cycles %0d responses %0d required 40 0", ar_cycles, got_q.size());
    end
    @(negedge clk); resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1; ar_block = 1'b0;
`endif
    send_cmd(1'b0, 32'h87, 32'h0);
    exp_q.push_back({1'b0, 2'b00, model_mem[8'h87]});
    pop_pair(ok, g, e);
    compared++;
    if (!ok || g !== e) begin mismatched++; $display("FAIL tmo_recover: got %h (ok=%0d) required %h", g, ok, e); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      slv_mem[i] = '0;
      model_mem[i] = '0;
    end
    test_reset();
    test_write_read();
    test_ordering();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
